// File: rtl/result_collect_pkg.sv
// Shared types and helpers for the result-bit collector.
//   state_e    : collector FSM states
//   DEF_WIDTH  : default output word width
//   cnt_width  : width needed to hold a bit count of 0..w
package result_collect_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_STALL = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 8;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/result_hold_reg.sv
// Output holding register with valid/ready handshake.
//   load/load_data/load_count : new word from the collector (only asserted
//                               when the register is free or draining)
//   out_ready                 : consumer takes the word this cycle
//   out_valid/out_data/out_count/out_parity : registered word, stable while
//                               out_valid & !out_ready
module result_hold_reg
   import result_collect_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic [CNT_W-1:0] load_count,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_parity
);

   logic             valid_q,  valid_d;
   logic [WIDTH-1:0] data_q,   data_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             parity_q, parity_d;

   always_comb begin
      valid_d  = valid_q;
      data_d   = data_q;
      count_d  = count_q;
      parity_d = parity_q;
      // A load in the same cycle as a drain keeps valid high with new data.
      if (load) begin
         valid_d  = 1'b1;
         data_d   = load_data;
         count_d  = load_count;
         parity_d = ^load_data;
      end else if (valid_q && out_ready) begin
         valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         count_q  <= '0;
         parity_q <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         count_q  <= count_d;
         parity_q <= parity_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign out_count  = count_q;
   assign out_parity = parity_q;

endmodule

// File: rtl/result_bit_collector.sv
// Packs a qualified single-bit result stream, LSB first, into WIDTH-bit
// words and presents them on a valid/ready output with count and parity.
// A flush emits the partial word (zero padded); if the output register is
// busy the flush is held pending and input is stalled until it drains.
//   in_valid/in_bit/in_ready : bit stream input
//   flush                    : single-cycle partial-word request
//   out_*                    : registered word handshake
//   busy                     : FSM not idle
module result_bit_collector
   import result_collect_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_parity,
   output logic             busy
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic             busy_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic             flush_pend_q, flush_pend_d;

   logic             hold_free, accept, complete, load, ov_next;
   logic [CNT_W-1:0] eff_cnt;
   logic [WIDTH-1:0] sr_ins;

   always_comb begin
      hold_free    = !out_valid || out_ready;
      // Only the word-completing bit waits for the holding register.
      in_ready     = !flush_pend_q && ((cnt_q != LAST) || hold_free);
      accept       = in_valid && in_ready;
      complete     = accept && (cnt_q == LAST);
      eff_cnt      = cnt_q + CNT_W'(accept);
      // Positions at and above cnt_q are always zero, so OR inserts the bit.
      sr_ins       = sr_q | (WIDTH'(accept & in_bit) << cnt_q);

      load         = 1'b0;
      flush_pend_d = flush_pend_q;
      cnt_d        = eff_cnt;
      sr_d         = sr_ins;

      if (complete) begin
         // A coincident flush is absorbed: nothing is left after completion.
         load = 1'b1;
      end else if (flush_pend_q) begin
         if (hold_free) begin
            load         = 1'b1;
            flush_pend_d = 1'b0;
         end
      end else if (flush && (eff_cnt != '0)) begin
         if (hold_free) load = 1'b1;
         else           flush_pend_d = 1'b1;
      end

      if (load) begin
         cnt_d = '0;
         sr_d  = '0;
      end

      ov_next = load || (out_valid && !out_ready);

      if ((cnt_d == '0) && !ov_next && !flush_pend_d)
         state_d = S_IDLE;
      else if (((cnt_d == LAST) || flush_pend_d) && ov_next && !out_ready)
         state_d = S_STALL;
      else
         state_d = S_FILL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         busy_q       <= 1'b0;
         cnt_q        <= '0;
         sr_q         <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         busy_q       <= (state_d != S_IDLE);
         cnt_q        <= cnt_d;
         sr_q         <= sr_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign busy = busy_q;

   result_hold_reg #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_hold (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .load_data  (sr_ins),
      .load_count (eff_cnt),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_count  (out_count),
      .out_parity (out_parity)
   );

endmodule

// File: doc/result_bit_collector.md
Name: result_bit_collector

Overview:
- Downstream consumer stage for the single-bit `result` stream produced by the combinational/flip-flop test stage.
- Packs qualified result bits, LSB first, into WIDTH-bit words.
- Presents each word on a valid/ready output with bit count and even parity.
- Supports an explicit flush that emits a partial, zero-padded word. It gives the fault-injection test set a block with a counter, an FSM and a handshake.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of bit counter and out_count; derived, do not override.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  result bit from upstream stage.
- in_ready  output  1  collector accepts in_bit this cycle.
- flush  input  1  single-cycle request to emit the partial word.
- out_valid  output  1  holding register contains a word.
- out_ready  input  1  consumer takes the word this cycle.
- out_data  output  WIDTH  packed word; bit k = k-th accepted bit.
- out_count  output  CNT_W  number of valid bits in out_data (1..WIDTH).
- out_parity  output  1  XOR of out_data, registered with it.
- busy  output  1  FSM not in S_IDLE.

Behaviour:
- Reset (rst_n=0, async): FSM=S_IDLE, cnt_q=0, shift register=0, out_valid=0, out_data=0, out_count=0, out_parity=0, flush_pend=0. All effects are immediate, including mid-word and mid-handshake; partial bits are discarded.
- accept = in_valid & in_ready. Accepted bit is written to shift position cnt_q; cnt_q increments.
- drain = out_valid & out_ready. hold_free = !out_valid | out_ready.
- Word complete: accept with cnt_q==WIDTH-1.
  - If hold_free: next cycle out_valid=1, out_data = full word, out_count=WIDTH, cnt_q=0, shift register=0.
  - Latency: one cycle from the accepting edge of the last bit to out_valid.
- in_ready = !flush_pend & ((cnt_q != WIDTH-1) | hold_free). Backpressure applies only to the word-completing bit.
- Output register:
  - out_valid clears on drain, unless a new word loads in the same cycle; then it stays 1 with the new data.
  - out_data, out_count and out_parity are stable while out_valid & !out_ready.
- Flush:
  - eff_cnt = cnt_q + accept.
  - flush with eff_cnt==0: ignored.
  - flush with eff_cnt>0 and hold_free: emit a word next cycle. out_data = collected bits (including the bit accepted this cycle), upper bits 0, out_count=eff_cnt, cnt_q=0.
  - flush with eff_cnt>0 and !hold_free: set flush_pend=1 and deassert in_ready. Emit on the first cycle hold_free=1, then clear flush_pend.
  - flush while flush_pend=1: no additional effect.
  - Flush coinciding with word completion: the full word is emitted and flush is absorbed, because eff_cnt after completion is 0.
- FSM (busy=1 outside S_IDLE):
  - S_IDLE: cnt_q==0, !out_valid, !flush_pend.
  - S_FILL: cnt_q>0 or out_valid, not stalled.
  - S_STALL: (cnt_q==WIDTH-1 | flush_pend) & out_valid & !out_ready.
  - Transitions are evaluated each cycle from the next-state values. S_STALL exits to S_FILL or S_IDLE on drain.
- Counter: cnt_q never exceeds WIDTH-1 and never wraps.
- Parity: out_parity = ^out_data_next, registered; padding zeros do not affect it.

Decomposition:
- Package result_collect_pkg:
  - state_e typedef (S_IDLE, S_FILL, S_STALL).
  - Localparam for default WIDTH.
  - Function cnt_width(w) returning $clog2(w+1).
- One sub-module, result_hold_reg: the output holding register with valid/ready. It takes load, load_data, load_count and out_ready, and produces out_valid, out_data, out_count and out_parity.
- The FSM, counter and shift register stay in result_bit_collector.

Test Plan (WIDTH=8):
- Reset: rst_n=0 for 2 cycles, then 1 -> out_valid=0, out_data=0x00, out_count=0, in_ready=1, busy=0.
- Full word: out_ready=1, accept bits 1,0,1,1,0,0,0,1 on 8 consecutive cycles -> one cycle after 8th accept: out_valid=1, out_data=0x8D, out_count=8, out_parity=0 for exactly 1 cycle; busy=0 after.
- Backpressure: out_ready=0 with 0x8D held; stream 7 more bits -> all accepted; 8th bit sees in_ready=0, state S_STALL. Raise out_ready -> in_ready=1 same cycle. Next cycle out_valid=1 with the new word, and 0x8D was consumed exactly once.
- Flush partial: accept 1,1,0, then pulse flush (no bit that cycle) -> next cycle out_data=0x03, out_count=3, out_parity=0, cnt_q=0.
- Pending flush: out_ready=0 with word held, accept 2 bits 1,0, pulse flush -> flush_pend=1, in_ready=0 while in_valid stays 1. Raise out_ready -> old word drains, next cycle out_data=0x01, out_count=2, out_parity=1, in_ready=1.
- Reset mid-word: accept 5 bits 1,1,1,1,1, then pulse rst_n=0 -> outputs at reset values. Then accept 8 bits 0 -> out_data=0x00, out_count=8, out_parity=0, with no residue from the 5 discarded bits.
